// File: rtl/board_io_pkg.sv
// Shared definitions for board_io_ctrl: LED display mode encodings and a counter-width helper.
// Pure constants; no latency and no flow control involved.
package board_io_pkg;

  typedef enum logic [1:0] {
    LED_DIRECT = 2'd0,
    LED_BLINK  = 2'd1,
    LED_PWM    = 2'd2,
    LED_TEST   = 2'd3
  } led_mode_e;

  // Bits needed to hold 0..n-1, never less than one so a count of 1 still gets a real signal.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/io_debounce.sv
// One switch channel: two-flop synchroniser, tick-based debounce and edge pulses.
// sw_i to sync 2 cycles, sync to sw_o up to DB_TICKS ticks; free-running, no backpressure.
module io_debounce
  import board_io_pkg::*;
#(
  parameter int DB_TICKS = 10
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic tick_i,
  input  logic sw_i,
  output logic sw_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int DBW = clog2(DB_TICKS);
  localparam logic [DBW-1:0] DB_MAX = DBW'(DB_TICKS - 1);

  logic           meta_q, meta_d;
  logic           sync_q, sync_d;
  logic           stable_q, stable_d;
  logic           rise_q, rise_d;
  logic           fall_q, fall_d;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;

  always_comb begin
    meta_d   = sw_i;
    sync_d   = meta_q;
    stable_d = stable_q;
    db_cnt_d = db_cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    if (sync_q == stable_q) begin
      db_cnt_d = '0;
    end else if (tick_i) begin
      if (db_cnt_q == DB_MAX) begin
        // Pulses are registered alongside stable so they line up with sw_o changing.
        stable_d = sync_q;
        db_cnt_d = '0;
        rise_d   = sync_q;
        fall_d   = ~sync_q;
      end else begin
        db_cnt_d = db_cnt_q + DBW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign sw_o   = stable_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/board_io_ctrl.sv
// Board I/O conditioner: debounced switches with edge pulses, LEDs in direct/blink/PWM/walk modes.
// LED inputs to led_o 1 cycle; switch path see io_debounce; free-running, no backpressure.
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int SW_WIDTH    = 16,
  parameter int LED_WIDTH   = 16,
  parameter int TICK_DIV    = 100000,
  parameter int DB_TICKS    = 10,
  parameter int BLINK_TICKS = 250,
  parameter int PWM_BITS    = 8
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic [SW_WIDTH-1:0]  sw_i,
  output logic [SW_WIDTH-1:0]  sw_o,
  output logic [SW_WIDTH-1:0]  sw_rise_o,
  output logic [SW_WIDTH-1:0]  sw_fall_o,
  input  logic [LED_WIDTH-1:0] led_i,
  input  logic [1:0]           led_mode_i,
  input  logic [PWM_BITS-1:0]  led_duty_i,
  output logic [LED_WIDTH-1:0] led_o
);

  localparam int TDW = clog2(TICK_DIV);
  localparam int BKW = clog2(BLINK_TICKS);
  localparam logic [TDW-1:0] TICK_MAX  = TDW'(TICK_DIV - 1);
  localparam logic [BKW-1:0] BLINK_MAX = BKW'(BLINK_TICKS - 1);

  logic [TDW-1:0]       tick_cnt_q, tick_cnt_d;
  logic [BKW-1:0]       blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic [PWM_BITS-1:0]  pwm_cnt_q, pwm_cnt_d;
  logic [1:0]           mode_q, mode_d;
  logic [LED_WIDTH-1:0] walk_q, walk_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 tick, blink_evt, pwm_on;

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_db
    io_debounce #(.DB_TICKS(DB_TICKS)) u_db (
      .clk_i  (clk_i),
      .arst_i (arst_i),
      .tick_i (tick),
      .sw_i   (sw_i[g]),
      .sw_o   (sw_o[g]),
      .rise_o (sw_rise_o[g]),
      .fall_o (sw_fall_o[g])
    );
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_MAX);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TDW'(1);

    blink_evt   = tick && (blink_cnt_q == BLINK_MAX);
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (blink_evt) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end else if (tick) begin
      blink_cnt_d = blink_cnt_q + BKW'(1);
    end

    pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
    pwm_on    = (pwm_cnt_q < led_duty_i);

    // Entering TEST restarts the walk even if a blink event lands on the same cycle.
    mode_d = led_mode_i;
    walk_d = walk_q;
    if (led_mode_i == LED_TEST && mode_q != LED_TEST) begin
      walk_d = LED_WIDTH'(1);
    end else if (blink_evt) begin
      walk_d = {walk_q[LED_WIDTH-2:0], walk_q[LED_WIDTH-1]};
    end

    led_d = walk_d;
    case (led_mode_i)
      LED_DIRECT: led_d = led_i;
      LED_BLINK:  led_d = led_i & {LED_WIDTH{phase_q}};
      LED_PWM:    led_d = led_i & {LED_WIDTH{pwm_on}};
      default:    led_d = walk_d;
    endcase
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      tick_cnt_q  <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      pwm_cnt_q   <= '0;
      mode_q      <= 2'd0;
      walk_q      <= LED_WIDTH'(1);
      led_q       <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      pwm_cnt_q   <= pwm_cnt_d;
      mode_q      <= mode_d;
      walk_q      <= walk_d;
      led_q       <= led_d;
    end
  end

  assign led_o = led_q;

endmodule

// File: tb/tb_board_io_ctrl.sv
// Directed bench for board_io_ctrl with a fast timebase (tick every 4 cycles, 3-tick debounce).
module tb_board_io_ctrl;
  import board_io_pkg::*;

  logic        clk_i = 1'b0;
  logic        arst_i;
  logic [15:0] sw_i, sw_o, sw_rise_o, sw_fall_o;
  logic [15:0] led_i, led_o;
  logic [1:0]  led_mode_i;
  logic [3:0]  led_duty_i;

  int passed = 0;
  int total  = 0;
  int ecnt;
  int n_rise, n_fall, lat;
  logic [15:0] rise_val, fall_val;

  always #5 clk_i = ~clk_i;

  board_io_ctrl #(
    .SW_WIDTH(16), .LED_WIDTH(16), .TICK_DIV(4),
    .DB_TICKS(3), .BLINK_TICKS(2), .PWM_BITS(4)
  ) dut (
    .clk_i      (clk_i),
    .arst_i     (arst_i),
    .sw_i       (sw_i),
    .sw_o       (sw_o),
    .sw_rise_o  (sw_rise_o),
    .sw_fall_o  (sw_fall_o),
    .led_i      (led_i),
    .led_mode_i (led_mode_i),
    .led_duty_i (led_duty_i),
    .led_o      (led_o)
  );

  // Edges since reset release; the DUT tick falls in the cycle after an edge with ecnt%4==3.
  always @(posedge clk_i or posedge arst_i)
    if (arst_i) ecnt <= 0;
    else        ecnt <= ecnt + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_rng(input string tag, input int val, input int lo, input int hi);
    total++;
    assert (val >= lo && val <= hi) passed++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, val, lo, hi);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic watch(input int n);
    n_rise = 0; n_fall = 0; lat = -1; rise_val = '0; fall_val = '0;
    for (int i = 1; i <= n; i++) begin
      step(1);
      if (|sw_rise_o) begin
        n_rise++; rise_val |= sw_rise_o;
        if (lat < 0) lat = i;
      end
      if (|sw_fall_o) begin
        n_fall++; fall_val |= sw_fall_o;
        if (lat < 0) lat = i;
      end
    end
  endtask

  initial begin
    int bad, changes, last, on_cnt, wrap;
    logic [15:0] prev, first_chg, exp_walk;

    arst_i = 1'b1; sw_i = 16'h0001; led_i = '0; led_mode_i = LED_DIRECT; led_duty_i = '0;
    step(2);
    check("rst_sw_o", sw_o, 16'h0000);
    check("rst_rise", sw_rise_o, 16'h0000);
    check("rst_fall", sw_fall_o, 16'h0000);
    check("rst_led", led_o, 16'h0000);

    // Switch held high through reset is accepted as a rise after debounce.
    arst_i = 1'b0;
    watch(20);
    check("pwrup_rise_n", n_rise, 1);
    check("pwrup_rise_val", rise_val, 16'h0001);
    check("pwrup_fall_n", n_fall, 0);
    check_rng("pwrup_lat", lat, 11, 14);
    check("pwrup_sw_o", sw_o, 16'h0001);

    // Three-cycle glitch whose synchronised window contains exactly one tick.
    while (ecnt % 4 != 0) step(1);
    sw_i = 16'h0009;
    step(3);
    sw_i = 16'h0001;
    watch(16);
    check("glitch_sw_o", sw_o, 16'h0001);
    check("glitch_pulses", n_rise + n_fall, 0);

    sw_i = 16'h0009;
    watch(16);
    check("hold_rise_n", n_rise, 1);
    check("hold_rise_val", rise_val, 16'h0008);
    check("hold_fall_n", n_fall, 0);
    check_rng("hold_lat", lat, 11, 14);
    check("hold_sw_o", sw_o, 16'h0009);

    sw_i = 16'h0001;
    watch(16);
    check("rel_fall_n", n_fall, 1);
    check("rel_fall_val", fall_val, 16'h0008);
    check("rel_rise_n", n_rise, 0);
    check_rng("rel_lat", lat, 11, 14);
    check("rel_sw_o", sw_o, 16'h0001);

    led_i = 16'hA5A5;
    step(1);
    check("direct", led_o, 16'hA5A5);

    led_mode_i = LED_BLINK;
    bad = 0; changes = 0; last = -1; prev = '0;
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (led_o !== 16'hA5A5 && led_o !== 16'h0000) bad++;
      if (i > 0 && led_o !== prev) begin
        if (last >= 0 && i - last != 8) bad++;
        last = i;
        changes++;
      end
      prev = led_o;
    end
    check("blink_shape", bad, 0);
    check_rng("blink_changes", changes, 4, 5);

    led_mode_i = LED_PWM; led_i = 16'hFFFF;
    for (int d = 0; d < 3; d++) begin
      led_duty_i = (d == 0) ? 4'd4 : (d == 1) ? 4'd15 : 4'd0;
      step(1);
      on_cnt = 0; bad = 0;
      for (int i = 0; i < 32; i++) begin
        if (led_o === 16'hFFFF) on_cnt++;
        else if (led_o !== 16'h0000) bad++;
        step(1);
      end
      check("pwm_shape", bad, 0);
      check("pwm_on_cnt", on_cnt, (d == 0) ? 8 : (d == 1) ? 30 : 0);
    end

    led_i = 16'hA5A5; led_mode_i = LED_TEST;
    step(1);
    check("test_entry", led_o, 16'h0001);
    bad = 0; changes = 0; wrap = 0; prev = 16'h0001; first_chg = '0;
    for (int i = 0; i < 200 && changes < 17; i++) begin
      step(1);
      if (led_o !== prev) begin
        exp_walk = {prev[14:0], prev[15]};
        if (led_o !== exp_walk) bad++;
        if (prev == 16'h8000 && led_o == 16'h0001) wrap = 1;
        if (changes == 0) first_chg = led_o;
        changes++;
        prev = led_o;
      end
    end
    check("test_first_step", first_chg, 16'h0002);
    check("test_steps", changes, 17);
    check("test_rotate", bad, 0);
    check("test_wrap", wrap, 1);

    led_mode_i = LED_DIRECT; led_i = 16'h0000;
    step(3);
    check("test_leave", led_o, 16'h0000);
    led_mode_i = LED_TEST;
    step(1);
    check("test_reenter", led_o, 16'h0001);

    // Reset in the middle of a debounce and with blink running.
    led_mode_i = LED_BLINK; led_i = 16'hFFFF; sw_i = 16'h0021;
    step(8);
    check("mid_db_sw_o", sw_o, 16'h0001);
    #2 arst_i = 1'b1;
    #1;
    check("arst_sw_o", sw_o, 16'h0000);
    check("arst_rise", sw_rise_o, 16'h0000);
    check("arst_fall", sw_fall_o, 16'h0000);
    check("arst_led", led_o, 16'h0000);
    step(2);
    arst_i = 1'b0;
    step(1);
    check("post_rst_led", led_o, 16'h0000);
    check("post_rst_pulse", sw_rise_o | sw_fall_o, 16'h0000);
    watch(15);
    check_rng("post_rst_lat", lat, 10, 13);
    check("post_rst_rise_n", n_rise, 1);
    check("post_rst_rise_val", rise_val, 16'h0021);
    check("post_rst_fall_n", n_fall, 0);
    check("post_rst_sw_o", sw_o, 16'h0021);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
